// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: default widths, error codes and the
// I2OSP controller state encoding.
package rsa_pkg;

    localparam int RSA_DATA_BIT_WIDTH = 2048;
    localparam int RSA_MAX_OCTETS     = RSA_DATA_BIT_WIDTH / 8;
    localparam int RSA_LEN_W          = 9;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_TOO_LARGE = 2'b01,
        ERR_BAD_LEN   = 2'b10
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2,
        ERR   = 2'd3
    } i2osp_state_e;

endpackage

// File: rtl/i2osp_len_check.sv
// Combinational length/range check for an octet-addressed integer:
// flags illegal lengths and any nonzero octet at or above the requested length.
module i2osp_len_check
    import rsa_pkg::*;
#(
    parameter int NUM_OCTETS = RSA_MAX_OCTETS,
    parameter int MAX_OCTETS = RSA_MAX_OCTETS,
    parameter int LEN_W      = RSA_LEN_W
) (
    input  logic [NUM_OCTETS-1:0][7:0] x_i,
    input  logic [LEN_W-1:0]           len_i,
    output logic                       too_large_o,
    output logic                       bad_len_o
);

    logic [NUM_OCTETS-1:0] nonzero;
    logic [NUM_OCTETS-1:0] upper_mask;

    // A per-octet compare against a constant index keeps this a flat
    // OR-reduction instead of a 2048-bit barrel shifter.
    for (genvar k = 0; k < NUM_OCTETS; k++) begin : g_octet
        assign nonzero[k]    = |x_i[k];
        assign upper_mask[k] = (LEN_W'(k) >= len_i);
    end

    assign too_large_o = |(nonzero & upper_mask);
    assign bad_len_o   = (len_i == '0) || (len_i > LEN_W'(MAX_OCTETS));

endmodule

// File: rtl/i2osp.sv
// Integer-to-Octet-String primitive: latches an integer and a length, checks
// the range, then streams the octets MSB-first over a valid/ready handshake.
module i2osp
    import rsa_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = RSA_DATA_BIT_WIDTH,
    parameter int MAX_OCTETS     = DATA_BIT_WIDTH / 8,
    parameter int LEN_W          = RSA_LEN_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [DATA_BIT_WIDTH-1:0] i_x,
    input  logic [LEN_W-1:0]          i_xlen,
    output logic [7:0]                o_octet,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic                      o_last,
    output logic                      o_err,
    output logic [1:0]                o_err_code,
    output logic                      busy
);

    localparam int NUM_OCTETS = DATA_BIT_WIDTH / 8;
    localparam int IDX_W      = (NUM_OCTETS > 1) ? $clog2(NUM_OCTETS) : 1;

    typedef logic [NUM_OCTETS-1:0][7:0] octets_t;

    i2osp_state_e     state_q, state_d;
    octets_t          x_q, x_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    err_code_e        code_q, code_d;

    logic too_large;
    logic bad_len;

    i2osp_len_check #(
        .NUM_OCTETS (NUM_OCTETS),
        .MAX_OCTETS (MAX_OCTETS),
        .LEN_W      (LEN_W)
    ) u_len_check (
        .x_i         (x_q),
        .len_i       (len_q),
        .too_large_o (too_large),
        .bad_len_o   (bad_len)
    );

    // NOTE: every always_comb target gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        len_d   = len_q;
        idx_d   = idx_q;
        code_d  = code_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = i_x;
                    len_d   = i_xlen;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Length errors win over range errors.
                if (bad_len) begin
                    code_d  = ERR_BAD_LEN;
                    state_d = ERR;
                end else if (too_large) begin
                    code_d  = ERR_TOO_LARGE;
                    state_d = ERR;
                end else begin
                    idx_d   = IDX_W'(len_q - LEN_W'(1));
                    state_d = SEND;
                end
            end
            SEND: begin
                if (o_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            ERR: begin
                code_d  = ERR_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide operand register is cleared too, so no stale
            // integer from an aborted transfer survives a reset.
            state_q <= IDLE;
            x_q     <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
        end
    end

    assign i_ready    = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign o_valid    = (state_q == SEND);
    assign o_octet    = (state_q == SEND) ? x_q[idx_q] : 8'h00;
    assign o_last     = (state_q == SEND) && (idx_q == '0);
    assign o_err      = (state_q == ERR);
    assign o_err_code = (state_q == ERR) ? code_q : ERR_NONE;

endmodule

// File: tb/tb_i2osp.sv
// Directed bench for i2osp: table of single requests plus hand-written
// sequences for the 256-octet, back-pressure and mid-stream reset cases.
module tb_i2osp;
    import rsa_pkg::*;

    localparam int DW = RSA_DATA_BIT_WIDTH;
    localparam int LW = RSA_LEN_W;

    typedef logic [7:0] octet_q_t[$];

    typedef struct {
        logic [DW-1:0] x;
        logic [LW-1:0] xlen;
        logic [1:0]    code;
        int            n;
        logic [63:0]   bytes;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_x;
    logic [LW-1:0] i_xlen;
    logic [7:0]    o_octet;
    logic          o_valid;
    logic          o_ready;
    logic          o_last;
    logic          o_err;
    logic [1:0]    o_err_code;
    logic          busy;

    int checks = 0;
    int errors = 0;

    i2osp dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_x        (i_x),
        .i_xlen     (i_xlen),
        .o_octet    (o_octet),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_last     (o_last),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a request at a negedge and returns at the negedge of the
    // cycle where the first octet or the error pulse is due (accept + 2).
    task automatic send_req(input string name, input logic [DW-1:0] x, input logic [LW-1:0] len);
        check({name, " i_ready before"}, i_ready, 1);
        i_valid = 1'b1;
        i_x     = x;
        i_xlen  = len;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_x     = {64{32'hDEAD_BEEF}};
        i_xlen  = 9'd3;
        check({name, " check-cycle o_valid"}, o_valid, 0);
        check({name, " check-cycle o_err"}, o_err, 0);
        check({name, " check-cycle busy"}, busy, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_err(input string name, input logic [1:0] code);
        check({name, " o_err"}, o_err, 1);
        check({name, " o_err_code"}, o_err_code, code);
        check({name, " o_valid during err"}, o_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({name, " o_err cleared"}, o_err, 0);
        check({name, " o_err_code cleared"}, o_err_code, 0);
        check({name, " i_ready after err"}, i_ready, 1);
    endtask

    task automatic stream_check(input string name, input octet_q_t exp, input bit rand_ready);
        int         j = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held_octet = 8'h00;
        logic       held_last = 1'b0;
        check({name, " first o_valid"}, o_valid, 1);
        while (j < exp.size() && cyc < 2000) begin
            if (stalled) begin
                check({name, " stall o_valid"}, o_valid, 1);
                check({name, " stall o_octet"}, o_octet, held_octet);
                check({name, " stall o_last"}, o_last, held_last);
            end
            o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_valid = (rand_ready && j < exp.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_x     = {64{$urandom}};
            i_xlen  = 9'd1;
            if (o_valid && o_ready) begin
                check($sformatf("%s octet %0d", name, j), o_octet, exp[j]);
                check($sformatf("%s last %0d", name, j), o_last, (j == exp.size() - 1));
                j++;
                stalled = 1'b0;
            end else begin
                stalled    = o_valid;
                held_octet = o_octet;
                held_last  = o_last;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (j < exp.size()) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d octets expected %0d", name, j, exp.size());
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        check({name, " o_valid after"}, o_valid, 0);
        check({name, " i_ready after"}, i_ready, 1);
        check({name, " busy after"}, busy, 0);
    endtask

    initial begin
        vec_t          vecs[10];
        octet_q_t      q;
        logic [DW-1:0] big;

        vecs[0] = '{2048'h0102_0304,      9'd4,   2'b00, 4, 64'h0102_0304};
        vecs[1] = '{2048'hAB,             9'd3,   2'b00, 3, 64'h00_00AB};
        vecs[2] = '{2048'h1_0000,         9'd2,   2'b01, 0, 64'h0};
        vecs[3] = '{2048'hFFFF,           9'd2,   2'b00, 2, 64'hFFFF};
        vecs[4] = '{2048'h5,              9'd0,   2'b10, 0, 64'h0};
        vecs[5] = '{2048'h0,              9'd257, 2'b10, 0, 64'h0};
        vecs[6] = '{2048'h1,              9'd4,   2'b00, 4, 64'h0000_0001};
        vecs[7] = '{2048'h1 << 2040,      9'd255, 2'b01, 0, 64'h0};
        vecs[8] = '{2048'h100,            9'd1,   2'b01, 0, 64'h0};
        vecs[9] = '{2048'h55,             9'd1,   2'b00, 1, 64'h55};

        reset   = 1'b1;
        i_valid = 1'b0;
        i_x     = '0;
        i_xlen  = '0;
        o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset i_ready", i_ready, 1);
        check("reset o_valid", o_valid, 0);
        check("reset o_last", o_last, 0);
        check("reset o_err", o_err, 0);
        check("reset o_err_code", o_err_code, 0);
        check("reset busy", busy, 0);
        check("reset o_octet", o_octet, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            string nm = $sformatf("vec%0d", i);
            send_req(nm, vecs[i].x, vecs[i].xlen);
            if (vecs[i].code != 2'b00) begin
                expect_err(nm, vecs[i].code);
            end else begin
                q = {};
                for (int k = vecs[i].n - 1; k >= 0; k--) begin
                    q.push_back(vecs[i].bytes[8*k +: 8]);
                end
                stream_check(nm, q, 1'b0);
            end
        end

        // 256-octet maximum: 0x80 followed by 255 zero octets.
        big       = '0;
        big[2047] = 1'b1;
        send_req("max", big, 9'd256);
        q = {8'h80};
        for (int k = 0; k < 255; k++) q.push_back(8'h00);
        stream_check("max", q, 1'b0);

        // Random back-pressure with stray i_valid pulses while busy.
        send_req("stall", 2048'h1122_3344, 9'd4);
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        stream_check("stall", q, 1'b1);

        // Reset after the second octet of an 8-octet transfer.
        send_req("abort", 2048'h1122_3344_5566_7788, 9'd8);
        o_ready = 1'b1;
        check("abort octet 0", o_octet, 8'h11);
        @(posedge clk);
        @(negedge clk);
        check("abort octet 1", o_octet, 8'h22);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort o_valid", o_valid, 0);
        check("abort i_ready", i_ready, 1);
        check("abort busy", busy, 0);
        check("abort o_octet", o_octet, 0);
        send_req("post-abort", 2048'h55, 9'd1);
        q = {8'h55};
        stream_check("post-abort", q, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2osp.md
Name: i2osp

Overview:
- Integer-to-Octet-String Primitive per PKCS#1: the decoder counterpart of the OS2IP encoder in the RSA datapath.
- Takes a nonnegative integer from the RSA core, typically mod_exp output of width DATA_BIT_WIDTH, plus a requested octet length xLen.
- Streams xLen octets out, most significant first, over a valid/ready handshake to the framing/network layer.
- Flags "integer too large" (x >= 256^xLen) and illegal lengths instead of emitting data.

Parameters:
- DATA_BIT_WIDTH, 2048, width of integer input; must be a multiple of 8.
- MAX_OCTETS, DATA_BIT_WIDTH/8 (256), largest legal xLen.
- LEN_W, 9, width of the length field; must hold MAX_OCTETS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  request valid; i_x and i_xlen are sampled when i_valid && i_ready
- i_ready  out  1  block idle and able to accept a request
- i_x  in  DATA_BIT_WIDTH  integer x, bit 0 is LSB
- i_xlen  in  LEN_W  requested octet count xLen
- o_octet  out  8  current output octet
- o_valid  out  1  o_octet valid
- o_ready  in  1  downstream accepts octet
- o_last  out  1  asserted with the final octet (x_0)
- o_err  out  1  one-cycle pulse: request rejected, no octets emitted
- o_err_code  out  2  01 = integer too large; 10 = bad length; valid with o_err, else 00
- busy  out  1  not in IDLE

Behaviour:
- Reset: all outputs and registers are set as follows. State IDLE, i_ready = 1, o_valid = 0, o_last = 0, o_err = 0, o_err_code = 00, busy = 0, o_octet = 0. Reset at any time, including mid-stream, aborts the transfer immediately; the partial string is not completed.
- State machine: IDLE, CHECK, SEND, ERR.
- IDLE:
  - i_ready = 1.
  - On i_valid: latch i_x into x_reg and i_xlen into len_reg, then go to CHECK.
- CHECK (exactly one cycle):
  - If len_reg == 0 or len_reg > MAX_OCTETS: go to ERR with code 10.
  - Else compute too_large = OR over k in [len_reg, MAX_OCTETS-1] of (x_reg[8k+7:8k] != 0). Implement as per-octet nonzero flags ANDed with a "k >= len_reg" mask, not as a wide shift.
  - If too_large: go to ERR with code 01.
  - Otherwise load idx = len_reg-1 and go to SEND.
  - Length errors take priority over too-large errors.
- SEND:
  - o_valid = 1, o_octet = x_reg[8*idx +: 8], o_last = (idx == 0).
  - On o_valid && o_ready:
    - If idx == 0, go to IDLE.
    - Else decrement idx.
  - While o_ready = 0, o_octet and o_last are held stable and o_valid stays high.
  - One octet per cycle when o_ready is held high.
- ERR (one cycle): o_err = 1 and o_err_code set; then return to IDLE.
- Latency: a request accepted in cycle N gives first o_valid (or o_err) in cycle N+2.
- Throughput: xLen+2 cycles per request at full o_ready. The next request may be accepted in the cycle after the last handshake.
- Padding: xLen larger than the significant octets of x yields leading 0x00 octets (e.g. x=1, xLen=4 -> 00 00 00 01).
- i_x changing after acceptance has no effect. i_valid while busy is ignored (i_ready = 0).
- Endianness beyond MSB-first octet order is handled by the upper module.

Decomposition:
- Shared package rsa_pkg holds:
  - DATA_BIT_WIDTH and MAX_OCTETS defaults.
  - Error code constants: ERR_NONE=00, ERR_TOO_LARGE=01, ERR_BAD_LEN=10.
  - The state enum typedef {IDLE, CHECK, SEND, ERR}.
- One natural sub-module, i2osp_len_check: combinational per-octet nonzero and mask reduction producing too_large and bad_len. It is reusable by the EMSA/padding checks. The FSM and the output mux stay in i2osp.

Test Plan:
- x=0x0102_0304, xLen=4, o_ready=1 -> octets 01,02,03,04 on consecutive cycles; o_last with 04; first o_valid 2 cycles after accept; then i_ready=1.
- x=0xAB, xLen=3 -> 00,00,AB; o_last on AB; no o_err.
- x=0x1_0000, xLen=2 -> o_err pulse with code 01, no o_valid; x=0xFFFF, xLen=2 -> FF,FF with no error (boundary 256^xLen-1).
- xLen=0 and xLen=257 -> o_err with code 10; xLen=256 with x=2^2047 -> 80 followed by 255 octets of 00.
- o_ready toggled randomly during x=0x11223344, xLen=4 -> octet/o_last held stable while stalled; exact sequence 11,22,33,44 delivered; i_valid pulses while busy are ignored.
- reset asserted after the 2nd octet of an 8-octet transfer -> next cycle o_valid=0, i_ready=1; a new request x=0x55, xLen=1 then yields 55 with o_last.
